// File: rtl/hsid_rst_pkg.sv
// Shared types for the HSID reset sequencer: reset causes, sequencer states, counter width.
// The optional reset-event counter is enabled with HSID_RST_SEQ_CNT_EN.
package hsid_rst_pkg;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        POR  = 2'd1,
        SW   = 2'd2,
        WDT  = 2'd3
    } rst_cause_e;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2
    } rst_seq_state_e;

    localparam int RST_COUNT_W = 8;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/hsid_sat_cnt.sv
// Saturating up-counter with enable; powers up at zero and is never reset.
// Instantiated by hsid_rst_seq only when HSID_RST_SEQ_CNT_EN is defined.
module hsid_sat_cnt #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              en,
    output logic [DATA_W-1:0] q
);

    // Power-up value comes from the FPGA bitstream; reset events must not clear it.
    logic [DATA_W-1:0] cnt_q = '0;

    always_ff @(posedge clk) begin
        if (en && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/hsid_rst_seq.sv
// Staged reset sequencer: stretches any reset to MIN_PULSE cycles, then releases domains 0..N-1
// every RELEASE_GAP cycles. Optional reset-event counter enabled by HSID_RST_SEQ_CNT_EN.
module hsid_rst_seq
    import hsid_rst_pkg::*;
#(
    parameter int NUM_DOMAINS = 4,
    parameter int MIN_PULSE   = 16,
    parameter int RELEASE_GAP = 4
) (
    input  logic                   clk,
    input  logic                   rst_sync,
    input  logic                   sw_rst_req,
    output logic                   sw_rst_ack,
    input  logic                   wdt_expire,
    output logic [NUM_DOMAINS-1:0] rst_out,
    output logic                   busy,
    output logic                   done,
    output rst_cause_e             rst_cause,
    output logic [RST_COUNT_W-1:0] rst_count
);

    localparam int CNT_W = $clog2(max_int(MIN_PULSE, RELEASE_GAP)) + 1;

    localparam logic [CNT_W-1:0]       HOLD_LAST = CNT_W'(MIN_PULSE - 1);
    localparam logic [CNT_W-1:0]       GAP_LAST  = CNT_W'(RELEASE_GAP - 1);
    localparam logic [NUM_DOMAINS-1:0] ALL_ON    = '1;

    localparam logic [1:0] S_HOLD    = HOLD;
    localparam logic [1:0] S_RELEASE = RELEASE;
    localparam logic [1:0] S_RUN     = RUN;

    logic [1:0]             state;
    logic [CNT_W-1:0]       cnt;
    logic [NUM_DOMAINS-1:0] rst_shift;
    logic                   in_run;
    logic                   restart;
    logic                   step_due;

    // Domains release low index first, so each step shifts one more zero in from the bottom.
    assign rst_shift = rst_out << 1;
    assign in_run    = (state == S_RUN);
    // A software request is only honoured in RUN; it stays pending otherwise.
    assign restart   = wdt_expire | (in_run & sw_rst_req);
    assign step_due  = ((state == S_HOLD)    && (cnt == HOLD_LAST)) ||
                       ((state == S_RELEASE) && (cnt == GAP_LAST));

    always_ff @(posedge clk) begin
        sw_rst_ack <= 1'b0;
        if (rst_sync) begin
            state     <= S_HOLD;
            cnt       <= '0;
            rst_out   <= ALL_ON;
            rst_cause <= POR;
        end else if (restart) begin
            state      <= S_HOLD;
            cnt        <= '0;
            rst_out    <= ALL_ON;
            rst_cause  <= wdt_expire ? WDT : SW;
            sw_rst_ack <= in_run & sw_rst_req;
        end else begin
            case (state)
                S_HOLD, S_RELEASE: begin
                    if (step_due) begin
                        cnt     <= '0;
                        rst_out <= rst_shift;
                        state   <= (rst_shift == '0) ? S_RUN : S_RELEASE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RUN: begin
                    cnt <= '0;
                end
                default: begin
                    state   <= S_HOLD;
                    cnt     <= '0;
                    rst_out <= ALL_ON;
                end
            endcase
        end
    end

    assign busy = ~in_run;
    assign done = in_run;

`ifdef HSID_RST_SEQ_CNT_EN
    logic cnt_inc;

    // Only SW/WDT restarts count; rst_sync has priority and suppresses the increment.
    assign cnt_inc = ~rst_sync & restart;

    hsid_sat_cnt #(
        .DATA_W(RST_COUNT_W)
    ) u_rst_cnt (
        .clk (clk),
        .en  (cnt_inc),
        .q   (rst_count)
    );
`else
    assign rst_count = '0;
`endif

endmodule

// File: doc/hsid_rst_seq.md
Name: hsid_rst_seq

Overview:
Reset sequencer sitting downstream of the reset synchronizer: it consumes the already-synchronized system reset and generates staged, per-domain reset outputs for the HSID datapath blocks. It stretches every reset to a minimum pulse width and releases the domains in a fixed order with a programmable gap. It also accepts software reset requests (req/ack handshake) and watchdog expiry pulses, and records the cause of the last reset.

Parameters:
NUM_DOMAINS, 4, number of reset outputs; released in index order, 0 first; must be >= 1.
MIN_PULSE, 16, cycles all outputs stay asserted after the last reset source goes away; must be >= 2.
RELEASE_GAP, 4, cycles between successive domain releases; must be >= 1.
CNT_W, $clog2(max(MIN_PULSE,RELEASE_GAP))+1, internal counter width; derived, not overridden.

Ports:
clk  input  1  system clock.
rst_sync  input  1  synchronous active-high reset, sampled on rising clk.
sw_rst_req  input  1  software reset request; level, held by requester until ack.
sw_rst_ack  output  1  one-cycle pulse acknowledging sw_rst_req.
wdt_expire  input  1  one-cycle watchdog expiry pulse.
rst_out  output  NUM_DOMAINS  active-high per-domain resets.
busy  output  1  sequence in progress (HOLD or RELEASE).
done  output  1  all domains released (state RUN).
rst_cause  output  2  cause of the most recent reset (hsid_rst_pkg::rst_cause_e).
rst_count  output  8  reset-event counter (see Optional Feature).

Behaviour:
- Interface: one clock (clk); reset rst_sync is synchronous and active-high. All state updates on rising clk.
- States: HOLD, RELEASE, RUN.
- While rst_sync=1 (registered values): state=HOLD, cnt=0, rst_out=all 1s, busy=1, done=0, sw_rst_ack=0, rst_cause=POR. rst_count is not cleared by rst_sync.
- HOLD: cnt increments each cycle. On the edge where cnt==MIN_PULSE-1: go to RELEASE, clear rst_out[0], cnt=0. Net effect: rst_out[0] falls exactly MIN_PULSE cycles after the first edge that samples rst_sync=0.
- RELEASE: idx tracks the next domain. Every RELEASE_GAP cycles, clear rst_out[idx]. On the edge that clears rst_out[NUM_DOMAINS-1]: go to RUN, done=1, busy=0 (same edge).
- Total from rst_sync low to done high: MIN_PULSE + RELEASE_GAP*(NUM_DOMAINS-1) cycles. Defaults give 28.
- NUM_DOMAINS=1: HOLD goes directly to RUN.
- RUN, sw_rst_req=1: next edge enters HOLD, rst_out=all 1s, busy=1, done=0, rst_cause=SW, sw_rst_ack=1 for exactly that one cycle.
- RUN, wdt_expire=1: same transition with rst_cause=WDT.
- Simultaneous sw_rst_req and wdt_expire in RUN: rst_cause=WDT, sw_rst_ack still pulses.
- sw_rst_req high while not in RUN: ignored, no ack. The request stays pending and is served on the first RUN cycle.
- wdt_expire during HOLD or RELEASE: all rst_out reasserted, return to HOLD with cnt=0, rst_cause=WDT.
- rst_sync=1 at any point mid-sequence: immediate return to the reset values above (rst_cause=POR).
- Invariants: rst_out is monotonic during RELEASE, and rst_out[i]=0 implies rst_out[j]=0 for all j<i. Outputs are registered only, no combinational paths from inputs.

Optional Feature:
- Macro: HSID_RST_SEQ_CNT_EN.
- Defined: rst_count is an 8-bit saturating counter, 0 at power-up (initial value, FPGA-style). It increments on every entry to HOLD caused by SW or WDT, not by rst_sync, and saturates at 255.
- Undefined: rst_count is tied to 8'd0 and no counter logic is generated.

Decomposition:
- Package hsid_rst_pkg contains:
  - rst_cause_e (2-bit): NONE=0, POR=1, SW=2, WDT=3.
  - rst_seq_state_e: HOLD, RELEASE, RUN.
  - localparam RST_COUNT_W=8.
- One sub-module is natural: hsid_sat_cnt (parameterized-width saturating incrementer with enable), instantiated only under HSID_RST_SEQ_CNT_EN.
- Hold and gap counters stay inline.

Test Plan:
1. Power-up: rst_sync=1 for 5 cycles, then 0 -> rst_out=4'b1111 for 16 cycles; then 4'b1110, 4'b1100, 4'b1000, 4'b0000 at 4-cycle steps; done=1 at cycle 28; rst_cause=POR.
2. SW request: in RUN, raise sw_rst_req and hold it -> sw_rst_ack pulses exactly 1 cycle; rst_out=4'b1111 next edge; full 28-cycle re-sequence; rst_cause=SW. With macro defined, rst_count=1.
3. Watchdog mid-sequence: wdt_expire pulse 3 cycles into RELEASE -> rst_out returns to 4'b1111; HOLD restarts for 16 cycles; rst_cause=WDT; done is delayed accordingly.
4. Simultaneous: sw_rst_req and wdt_expire in the same RUN cycle -> rst_cause=WDT, single ack, single sequence. With macro defined, rst_count increments by 1.
5. Pending request: assert sw_rst_req during HOLD -> no ack until RUN; ack on the first RUN cycle, then a new sequence starts.
6. Mid-sequence POR: rst_sync=1 for 1 cycle during RELEASE -> all outputs return to reset values; rst_cause=POR; rst_count unchanged.
